// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// =====================================================================
// Package : pll_rst_seq_pkg
// Desc    : Shared state encodings and retry-counter helpers
// Rev     : 1.0
// =====================================================================
package pll_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int c_RETRY_W = 8;

    function automatic logic [c_RETRY_W-1:0] sat_inc(input logic [c_RETRY_W-1:0] v);
        return (v == '1) ? v : v + c_RETRY_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_rst_seq_lock_filter.sv
`default_nettype none
// =====================================================================
// Module : pll_rst_seq_lock_filter
// Desc   : Lock synchroniser with acceptance and loss debounce counters
// Rev    : 1.0
// =====================================================================
module pll_rst_seq_lock_filter
    import pll_rst_seq_pkg::*;
#(
    parameter int LOCK_FILT = 16,
    parameter int LOSS_FILT = 4
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_clear,
    input  logic I_pll_lock,
    output logic O_lock_ok,
    output logic O_lock_lost
);

    localparam int c_ACC_W  = $clog2(LOCK_FILT) + 1;
    localparam int c_LOSS_W = $clog2(LOSS_FILT) + 1;
    localparam logic [c_ACC_W-1:0]  c_ACC_LAST  = c_ACC_W'(LOCK_FILT - 1);
    localparam logic [c_LOSS_W-1:0] c_LOSS_LAST = c_LOSS_W'(LOSS_FILT - 1);

    logic [1:0]          r_sync;
    logic [c_ACC_W-1:0]  r_acc_cnt;
    logic [c_LOSS_W-1:0] r_loss_cnt;
    logic                w_synced;

    assign w_synced = r_sync[1];

    // Counters saturate one short of the threshold; the qualifying sample completes the run.
    assign O_lock_ok   = w_synced  && (r_acc_cnt  == c_ACC_LAST);
    assign O_lock_lost = !w_synced && (r_loss_cnt == c_LOSS_LAST);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_sync     <= 2'b00;
            r_acc_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], I_pll_lock};

            if (I_clear || !w_synced)
                r_acc_cnt <= '0;
            else if (r_acc_cnt != c_ACC_LAST)
                r_acc_cnt <= r_acc_cnt + c_ACC_W'(1);

            if (I_clear || w_synced)
                r_loss_cnt <= '0;
            else if (r_loss_cnt != c_LOSS_LAST)
                r_loss_cnt <= r_loss_cnt + c_LOSS_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// =====================================================================
// Module : pll_rst_seq
// Desc   : PLL reset/lock sequencer with retry and staggered channel resets
// Rev    : 1.0
// =====================================================================
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int RST_HOLD     = 200,
    parameter int LOCK_FILT    = 16,
    parameter int LOSS_FILT    = 4,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int CH_GAP       = 8
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_pll_lock,
    input  logic                 I_force_rst,
    output logic                 O_pll_rst,
    output logic [N_CH-1:0]      O_ch_rst,
    output logic                 O_locked,
    output logic                 O_timeout,
    output logic [c_RETRY_W-1:0] O_retry_cnt,
    output logic [1:0]           O_state
);

    localparam int c_HOLD_W = $clog2(RST_HOLD) + 1;
    localparam int c_TO_W   = $clog2(LOCK_TIMEOUT) + 1;
    localparam int c_REL_W  = $clog2(CH_GAP * N_CH) + 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_REL_W-1:0]  c_REL_LAST  = c_REL_W'(CH_GAP * N_CH - 1);

    state_e                 r_state;
    logic                   r_pll_rst;
    logic [N_CH-1:0]        r_ch_rst;
    logic                   r_locked;
    logic                   r_timeout;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic [c_TO_W-1:0]      r_to_cnt;
    logic [c_REL_W-1:0]     r_rel_cnt;

    logic w_lock_ok;
    logic w_lock_lost;
    logic w_filt_clear;
    logic w_go_hold;
    logic w_bump_retry;
    logic w_timeout;

    assign w_filt_clear = (r_state == ST_HOLD);

    pll_rst_seq_lock_filter #(
        .LOCK_FILT (LOCK_FILT),
        .LOSS_FILT (LOSS_FILT)
    ) u_lock_filter (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_clear     (w_filt_clear),
        .I_pll_lock  (I_pll_lock),
        .O_lock_ok   (w_lock_ok),
        .O_lock_lost (w_lock_lost)
    );

    // Force outranks loss/timeout and never counts as a retry; lock acceptance beats timeout.
    always_comb begin
        w_go_hold    = 1'b0;
        w_bump_retry = 1'b0;
        w_timeout    = 1'b0;
        if (I_force_rst) begin
            w_go_hold = 1'b1;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (!w_lock_ok && (r_to_cnt == c_TO_LAST)) begin
                        w_go_hold    = 1'b1;
                        w_bump_retry = 1'b1;
                        w_timeout    = 1'b1;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (w_lock_lost) begin
                        w_go_hold    = 1'b1;
                        w_bump_retry = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= ST_HOLD;
            r_pll_rst  <= 1'b1;
            r_ch_rst   <= '1;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b0;
            r_retry    <= '0;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
            r_rel_cnt  <= '0;
        end else begin
            r_timeout <= w_timeout;
            if (w_bump_retry)
                r_retry <= sat_inc(r_retry);

            if (w_go_hold) begin
                r_state    <= ST_HOLD;
                r_pll_rst  <= 1'b1;
                r_ch_rst   <= '1;
                r_locked   <= 1'b0;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    ST_HOLD: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state   <= ST_WAIT_LOCK;
                            r_pll_rst <= 1'b0;
                            r_to_cnt  <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_lock_ok) begin
                            r_state   <= ST_RELEASE;
                            r_rel_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        r_rel_cnt <= r_rel_cnt + c_REL_W'(1);
                        for (int k = 0; k < N_CH; k++) begin
                            if (r_rel_cnt == c_REL_W'(CH_GAP * (k + 1) - 1))
                                r_ch_rst[k] <= 1'b0;
                        end
                        if (r_rel_cnt == c_REL_LAST) begin
                            r_state  <= ST_RUN;
                            r_locked <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign O_pll_rst   = r_pll_rst;
    assign O_ch_rst    = r_ch_rst;
    assign O_locked    = r_locked;
    assign O_timeout   = r_timeout;
    assign O_retry_cnt = r_retry;
    assign O_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// =====================================================================
// Module : tb_pll_rst_seq
// Desc   : Self-checking bench for pll_rst_seq against a timeline model
// Rev    : 1.0
// =====================================================================
module tb_pll_rst_seq;

    localparam int N_CH         = 2;
    localparam int RST_HOLD     = 8;
    localparam int LOCK_FILT    = 4;
    localparam int LOSS_FILT    = 2;
    localparam int LOCK_TIMEOUT = 32;
    localparam int CH_GAP       = 3;
    localparam int MAXC         = 32768;

    logic            I_clk       = 1'b0;
    logic            I_rst       = 1'b1;
    logic            I_pll_lock  = 1'b1;
    logic            I_force_rst = 1'b0;
    logic            O_pll_rst;
    logic [N_CH-1:0] O_ch_rst;
    logic            O_locked;
    logic            O_timeout;
    logic [7:0]      O_retry_cnt;
    logic [1:0]      O_state;

    pll_rst_seq #(
        .N_CH         (N_CH),
        .RST_HOLD     (RST_HOLD),
        .LOCK_FILT    (LOCK_FILT),
        .LOSS_FILT    (LOSS_FILT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .CH_GAP       (CH_GAP)
    ) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_pll_lock  (I_pll_lock),
        .I_force_rst (I_force_rst),
        .O_pll_rst   (O_pll_rst),
        .O_ch_rst    (O_ch_rst),
        .O_locked    (O_locked),
        .O_timeout   (O_timeout),
        .O_retry_cnt (O_retry_cnt),
        .O_state     (O_state)
    );

    always #5 I_clk = ~I_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Timeline model: state plus the cycle each phase began, lock history as sampled bits.
    int m_state     = 0;
    int m_hold_ref  = 0;
    int m_wait_ent  = 0;
    int m_rel_ent   = 0;
    int m_retry     = 0;
    int m_last_rst  = 0;
    bit m_timeout   = 1'b0;
    bit raw_hist [MAXC];
    bit sync_hist[MAXC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int run_len(input int t, input int from, input bit val);
        int n = 0;
        for (int i = t; i >= from && i >= 0; i--) begin
            if (sync_hist[i] != val) break;
            n++;
        end
        return n;
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic model_step();
        raw_hist[cyc]  = I_pll_lock;
        sync_hist[cyc] = (cyc - 2 > m_last_rst) ? raw_hist[cyc-2] : 1'b0;
        m_timeout = 1'b0;
        if (I_rst) begin
            m_state = 0; m_hold_ref = cyc + 1; m_retry = 0; m_last_rst = cyc;
        end else if (I_force_rst) begin
            m_state = 0; m_hold_ref = cyc + 1;
        end else if (m_state == 0) begin
            if (cyc - m_hold_ref == RST_HOLD - 1) begin
                m_state = 1; m_wait_ent = cyc + 1;
            end
        end else if (m_state == 1) begin
            if (run_len(cyc, m_wait_ent, 1'b1) >= LOCK_FILT) begin
                m_state = 2; m_rel_ent = cyc + 1;
            end else if (cyc - m_wait_ent == LOCK_TIMEOUT - 1) begin
                m_state = 0; m_hold_ref = cyc + 1; m_timeout = 1'b1; m_retry = sat(m_retry);
            end
        end else begin
            if (run_len(cyc, m_rel_ent, 1'b0) >= LOSS_FILT) begin
                m_state = 0; m_hold_ref = cyc + 1; m_retry = sat(m_retry);
            end else if (m_state == 2 && cyc - m_rel_ent == CH_GAP * N_CH - 1) begin
                m_state = 3;
            end
        end
    endtask

    function automatic logic [14:0] model_out();
        logic [N_CH-1:0] ch;
        ch = '1;
        if (m_state >= 2)
            for (int k = 0; k < N_CH; k++)
                if (cyc - m_rel_ent >= CH_GAP * (k + 1)) ch[k] = 1'b0;
        return {2'(m_state), (m_state == 0), ch, (m_state == 3), m_timeout, 8'(m_retry)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {O_state, O_pll_rst, O_ch_rst, O_locked, O_timeout, O_retry_cnt};
    endfunction

    task automatic tick();
        model_step();
        @(posedge I_clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d got=overrun exp=<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        check_eq("model", 32'(dut_vec()), 32'(model_out()));
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    int base, g, c0, f1, e, lock_left, force_left;

    initial begin
        // Normal bring-up
        repeat (3) tick();
        I_rst = 1'b0;
        base = cyc;
        check_eq("rst_state",   32'(O_state),     0);
        check_eq("rst_pll_rst", 32'(O_pll_rst),   1);
        check_eq("rst_ch_rst",  32'(O_ch_rst),    3);
        check_eq("rst_locked",  32'(O_locked),    0);
        check_eq("rst_timeout", 32'(O_timeout),   0);
        check_eq("rst_retry",   32'(O_retry_cnt), 0);
        wait_until(base + 7);  check_eq("t1_pll_rst7", 32'(O_pll_rst), 1);
        wait_until(base + 8);  check_eq("t1_wait8",    32'(O_state), 1);
                               check_eq("t1_pll_rst8", 32'(O_pll_rst), 0);
        wait_until(base + 11); check_eq("t1_wait11",   32'(O_state), 1);
        wait_until(base + 12); check_eq("t1_rel12",    32'(O_state), 2);
        wait_until(base + 14); check_eq("t1_ch14",     32'(O_ch_rst), 3);
        wait_until(base + 15); check_eq("t1_ch15",     32'(O_ch_rst), 2);
        wait_until(base + 17); check_eq("t1_locked17", 32'(O_locked), 0);
        wait_until(base + 18); check_eq("t1_ch18",     32'(O_ch_rst), 0);
                               check_eq("t1_locked18", 32'(O_locked), 1);
                               check_eq("t1_run18",    32'(O_state), 3);
                               check_eq("t1_retry",    32'(O_retry_cnt), 0);

        // Glitches in RUN, then a real loss
        for (int i = 0; i < 3; i++) begin
            I_pll_lock = 1'b0; tick();
            I_pll_lock = 1'b1; repeat (5) tick();
        end
        check_eq("t3_glitch_run", 32'(O_state), 3);
        g = cyc;
        I_pll_lock = 1'b0; repeat (3) tick();
        I_pll_lock = 1'b1;
        wait_until(g + 4);
        check_eq("t3_loss_state",  32'(O_state), 0);
        check_eq("t3_loss_ch",     32'(O_ch_rst), 3);
        check_eq("t3_loss_locked", 32'(O_locked), 0);
        check_eq("t3_loss_retry",  32'(O_retry_cnt), 1);
        wait_until(g + 22); check_eq("t3_rerun", 32'(O_state), 3);

        // Force during RELEASE after ch0 release
        c0 = cyc;
        I_force_rst = 1'b1; tick(); I_force_rst = 1'b0;
        wait_until(c0 + 17);
        check_eq("t5_rel_ch0", 32'(O_ch_rst), 2);
        check_eq("t5_rel_st",  32'(O_state), 2);
        f1 = cyc;
        I_force_rst = 1'b1;
        tick();
        check_eq("t5_force_ch", 32'(O_ch_rst), 3);
        check_eq("t5_force_st", 32'(O_state), 0);
        repeat (4) tick();
        I_force_rst = 1'b0;
        wait_until(f1 + 12); check_eq("t5_hold12",  32'(O_state), 0);
        wait_until(f1 + 13); check_eq("t5_wait13",  32'(O_state), 1);
                             check_eq("t5_retry",   32'(O_retry_cnt), 1);
        wait_until(f1 + 25); check_eq("t5_run",     32'(O_state), 3);
        I_rst = 1'b1; tick(); I_rst = 1'b0;
        check_eq("t5_rst_state", 32'(O_state), 0);
        check_eq("t5_rst_pll",   32'(O_pll_rst), 1);
        check_eq("t5_rst_ch",    32'(O_ch_rst), 3);
        check_eq("t5_rst_lock",  32'(O_locked), 0);
        check_eq("t5_rst_retry", 32'(O_retry_cnt), 0);

        // Chatter in WAIT_LOCK, then acceptance on the timeout cycle
        base = cyc;
        for (int i = 0; i < 40; i++) begin
            I_pll_lock = (i % 4 != 3);
            if (i == 39) begin
                check_eq("t4_pre_to_st", 32'(O_state), 1);
                check_eq("t4_pre_to",    32'(O_timeout), 0);
            end
            tick();
        end
        check_eq("t4_to",       32'(O_timeout), 1);
        check_eq("t4_to_state", 32'(O_state), 0);
        check_eq("t4_to_retry", 32'(O_retry_cnt), 1);
        I_pll_lock = 1'b0;
        e = base + 48;
        wait_until(e + 26);
        I_pll_lock = 1'b1;
        wait_until(e + 31); check_eq("t4_edge_wait", 32'(O_state), 1);
        wait_until(e + 32); check_eq("t4_edge_rel",  32'(O_state), 2);
                            check_eq("t4_edge_to",   32'(O_timeout), 0);
                            check_eq("t4_edge_retry", 32'(O_retry_cnt), 1);

        // Lock never asserts: repeated timeouts, retry saturates
        I_rst = 1'b1; tick(); I_rst = 1'b0;
        I_pll_lock = 1'b0;
        base = cyc;
        for (int k = 0; k < 300; k++) begin
            wait_until(base + 40 + 40 * k);
            check_eq("t2_to_pulse", 32'(O_timeout), 1);
            check_eq("t2_retry",    32'(O_retry_cnt), 32'((k + 1 > 255) ? 255 : k + 1));
        end
        check_eq("t2_retry_sat", 32'(O_retry_cnt), 255);

        // Randomised lock and force activity against the model
        I_rst = 1'b1; tick(); I_rst = 1'b0;
        lock_left  = 0;
        force_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lock_left == 0) begin
                I_pll_lock = ($urandom_range(0, 3) != 0);
                lock_left  = I_pll_lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
            end
            lock_left--;
            if (force_left == 0 && $urandom_range(0, 249) == 0)
                force_left = int'($urandom_range(1, 6));
            I_force_rst = (force_left != 0);
            if (force_left != 0) force_left--;
            I_rst = ($urandom_range(0, 1499) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
